sram_arb: RTL and testbench
===========================

Name: sram_arb

Overview:
- Sequences the board's 16-bit asynchronous SRAM (18-bit word address) and shares it between two requesters.
  - The SXGA video fetch path has fixed high priority.
  - A host port (CPU or debug) has read/write access with byte enables.
- Sits between the video engine and the SRAM pins in the 108 MHz clock domain, and owns every SRAM control pin and the data-bus tristate.
- A starvation guard guarantees host progress under continuous video traffic.

Parameters:
- ACC_CYC, 2, clk cycles per SRAM access phase; legal range 2..15.
- HOST_MAX_WAIT, 4, consecutive video grants allowed while a host request is pending; 0 disables the guard (pure video priority).

Ports:
- clk  in  1  108 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- vid_req  in  1  video read request; held until vid_ack
- vid_addr  in  18  video word address; stable while vid_req high
- vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle
- vid_data  out  16  video read data; holds its value until the next video ack
- host_req  in  1  host request; held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_be  in  2  byte enables for writes, [1] = upper byte
- host_addr  in  18  host word address
- host_wdata  in  16  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  16  host read data, valid with host_ack on reads
- sram_dq  inout  16  SRAM data bus
- sram_addr  out  18  SRAM address
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset and idle values:
  - Strobes (ce/oe/we/ub/lb) = 1.
  - sram_dq = Z, sram_addr = 0.
  - vid_ack = host_ack = 0.
  - vid_data = host_rdata = 0.
  - Wait counter = 0, state = IDLE.
- All outputs are registered; there are no combinational paths from inputs to pins.
- FSM states IDLE, ACC, DONE:
  - IDLE: arbitrate at each edge.
    - Grant host if host_req and (no vid_req, or HOST_MAX_WAIT != 0 and wait_cnt == HOST_MAX_WAIT).
    - Otherwise grant video if vid_req.
    - Otherwise stay in IDLE.
    - On grant, latch address, we, be and wdata; go to ACC with the phase counter at 0.
  - ACC: lasts exactly ACC_CYC cycles. sram_addr = latched address and ce_n = 0 throughout.
    - Read: oe_n = 0, ub_n = lb_n = 0, dq = Z. Data is sampled from sram_dq at the edge ending the last ACC cycle.
    - Write: oe_n = 1, ub_n = ~be[1], lb_n = ~be[0], dq driven with wdata for all ACC cycles. we_n = 0 for cycles 0..ACC_CYC-2 and we_n = 1 in the final cycle, giving address/data hold past the we_n rising edge.
    - Exit to DONE.
  - DONE: strobes return to idle and dq = Z. The granted requester's ack = 1 for this cycle only. Read data is presented on vid_data or host_rdata. Next state is IDLE.
  - No request is sampled in DONE, so the requester may update its address or drop req in the ack cycle.
- Latency: request sampled at edge t -> ack high during cycle t+ACC_CYC+1. Throughput is one access per ACC_CYC+2 cycles.
- Wait counter:
  - Increments (saturating at HOST_MAX_WAIT) on each video grant made while host_req = 1.
  - Clears on host grant, and when host_req = 0 in IDLE.
- A host write with be = 00 still runs a full cycle with ub_n = lb_n = 1; this is harmless, and the ack is still given.
- If req is dropped mid-access, the access still completes and acks. Dropping req before ack is a protocol violation that the block tolerates.
- Asynchronous reset mid-access:
  - Pins go to idle values immediately.
  - No ack is issued for the aborted access.
  - An aborted write may be partially committed; this is acceptable.
- Simultaneous vid_req and host_req with the counter below the limit: video wins.
- Only one owner exists at a time; both acks are never high in the same cycle.

Decomposition:
- Package sram_arb_pkg:
  - SRAM_AW = 18, SRAM_DW = 16.
  - State enum {IDLE, ACC, DONE}.
  - Owner enum {OWN_VID, OWN_HOST}.
- Sub-module sram_pins:
  - Registered strobe, address and dq-output/oe flops plus the sram_dq tristate and the read-capture register.
  - Driven by the FSM's next-cycle controls.
- The FSM, arbitration and counters live in sram_arb.

Test Plan:
- Video read, ACC_CYC=2: vid_req at addr 0x00123 with the SRAM model holding 0xBEEF there -> ce_n/oe_n low for 2 cycles, sram_addr = 0x00123; vid_ack pulses 3 cycles after sampling with vid_data = 0xBEEF.
- Host write, be = 01, addr 0x3FFFF, data 0xA55A -> lb_n = 0, ub_n = 1, we_n low 1 cycle then high 1 cycle with dq still driven; model low byte = 0x5A and upper byte unchanged; host_ack pulses once.
- Collision with HOST_MAX_WAIT = 4: vid_req held continuously and host read asserted -> exactly 4 video acks, then host_ack, then video resumes; no cycle has both acks.
- Guard disabled, HOST_MAX_WAIT = 0: continuous vid_req for 100 accesses -> host_ack never asserts; dropping vid_req -> host is granted the next IDLE cycle.
- Reset mid-write in ACC cycle 0 -> all strobes = 1 and dq = Z in the same cycle; no ack after reset release; the next host request completes normally.
- Back-to-back video with a new address each ack cycle, 0x00000..0x00003 -> 4 acks spaced exactly ACC_CYC+2 cycles apart with matching data.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the async SRAM arbiter.
package sram_arb_pkg;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  typedef enum logic {OWN_VID, OWN_HOST} owner_t;
endpackage

// File: rtl/sram_arb_pins.sv
// SRAM pin flops, data-bus tristate and read-capture registers, loaded from next-cycle controls.
module sram_pins
  import sram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_en,
  input  logic [SRAM_AW-1:0] addr_d,
  input  logic [SRAM_DW-1:0] wdata_d,
  input  logic               ce_n_d,
  input  logic               oe_n_d,
  input  logic               we_n_d,
  input  logic               ub_n_d,
  input  logic               lb_n_d,
  input  logic               dq_oe_d,
  input  logic               cap_vid,
  input  logic               cap_host,
  output logic [SRAM_DW-1:0] vid_data,
  output logic [SRAM_DW-1:0] host_rdata,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;

  assign sram_dq = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      dq_oe      <= 1'b0;
      sram_addr  <= '0;
      vid_data   <= '0;
      host_rdata <= '0;
    end else begin
      sram_ce_n <= ce_n_d;
      sram_oe_n <= oe_n_d;
      sram_we_n <= we_n_d;
      sram_ub_n <= ub_n_d;
      sram_lb_n <= lb_n_d;
      dq_oe     <= dq_oe_d;
      if (ld_en) sram_addr <= addr_d;
      // Bus is sampled on the edge that closes the last access cycle.
      if (cap_vid)  vid_data   <= sram_dq;
      if (cap_host) host_rdata <= sram_dq;
    end
  end

  // Write data only reaches the bus while dq_oe is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ld_en) dq_out <= wdata_d;
  end
endmodule

// File: rtl/sram_arb.sv
// Two-port async SRAM sequencer: video fetch has priority, host is protected by a starvation guard.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int ACC_CYC       = 2,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_addr,
  output logic               vid_ack,
  output logic [SRAM_DW-1:0] vid_data,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [1:0]         host_be,
  input  logic [SRAM_AW-1:0] host_addr,
  input  logic [SRAM_DW-1:0] host_wdata,
  output logic               host_ack,
  output logic [SRAM_DW-1:0] host_rdata,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);
  localparam logic [3:0] LAST_PH  = 4'(ACC_CYC - 1);
  localparam logic [7:0] WAIT_LIM = 8'(HOST_MAX_WAIT);

  state_t     state;
  owner_t     owner;
  logic [3:0] phase;
  logic [7:0] wait_cnt;
  logic       lat_we;
  logic [1:0] lat_be;

  logic       guard_hit, grant_host, grant_vid;
  logic       nxt_acc, nxt_we;
  logic [1:0] nxt_be;
  logic [3:0] nxt_phase;
  logic       last_rd;

  assign guard_hit = (HOST_MAX_WAIT != 0) && (wait_cnt == WAIT_LIM);

  always_comb begin
    grant_host = 1'b0;
    grant_vid  = 1'b0;
    if (state == IDLE) begin
      if (host_req && (!vid_req || guard_hit)) grant_host = 1'b1;
      else if (vid_req)                        grant_vid  = 1'b1;
    end
  end

  // Describe the access as it will look during the coming cycle.
  always_comb begin
    nxt_acc   = 1'b0;
    nxt_phase = '0;
    nxt_we    = lat_we;
    nxt_be    = lat_be;
    case (state)
      IDLE: begin
        nxt_acc = grant_host | grant_vid;
        nxt_we  = grant_host & host_we;
        nxt_be  = grant_host ? host_be : 2'b11;
      end
      ACC: begin
        nxt_acc   = (phase != LAST_PH);
        nxt_phase = phase + 4'd1;
      end
      default: ;
    endcase
  end

  assign last_rd = (state == ACC) && (phase == LAST_PH) && !lat_we;

  sram_pins u_pins (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_en      (grant_host | grant_vid),
    .addr_d     (grant_host ? host_addr : vid_addr),
    .wdata_d    (host_wdata),
    .ce_n_d     (~nxt_acc),
    .oe_n_d     (~(nxt_acc & ~nxt_we)),
    // we_n rises one cycle before the access ends for address/data hold.
    .we_n_d     (~(nxt_acc & nxt_we & (nxt_phase < LAST_PH))),
    .ub_n_d     (~(nxt_acc & (~nxt_we | nxt_be[1]))),
    .lb_n_d     (~(nxt_acc & (~nxt_we | nxt_be[0]))),
    .dq_oe_d    (nxt_acc & nxt_we),
    .cap_vid    (last_rd && owner == OWN_VID),
    .cap_host   (last_rd && owner == OWN_HOST),
    .vid_data   (vid_data),
    .host_rdata (host_rdata),
    .sram_dq    (sram_dq),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_VID;
      phase    <= '0;
      wait_cnt <= '0;
      lat_we   <= 1'b0;
      lat_be   <= 2'b00;
      vid_ack  <= 1'b0;
      host_ack <= 1'b0;
    end else begin
      vid_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!host_req) wait_cnt <= '0;
          if (grant_host) begin
            owner    <= OWN_HOST;
            lat_we   <= host_we;
            lat_be   <= host_be;
            wait_cnt <= '0;
            phase    <= '0;
            state    <= ACC;
          end else if (grant_vid) begin
            owner  <= OWN_VID;
            lat_we <= 1'b0;
            lat_be <= 2'b11;
            phase  <= '0;
            state  <= ACC;
            if (host_req && wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ACC: begin
          if (phase == LAST_PH) begin
            state <= DONE;
            if (owner == OWN_VID) vid_ack  <= 1'b1;
            else                  host_ack <= 1'b1;
          end else begin
            phase <= phase + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: one guarded instance with a memory model, one unguarded instance.
module tb_sram_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vid_req = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [17:0] vid_addr = '0, host_addr = '0;
  logic [1:0]  host_be = '0;
  logic [15:0] host_wdata = '0;
  logic        vid_ack, host_ack;
  logic [15:0] vid_data, host_rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  logic        vid_req0 = 1'b0, host_req0 = 1'b0, host_we0 = 1'b0;
  logic [17:0] vid_addr0 = '0, host_addr0 = '0;
  logic [1:0]  host_be0 = '0;
  logic [15:0] host_wdata0 = '0;
  logic        vid_ack0, host_ack0;
  logic [15:0] vid_data0, host_rdata0;
  wire  [15:0] sram_dq0;
  logic [17:0] sram_addr0;
  logic        ce_n0, oe_n0, we_n0, ub_n0, lb_n0;

  sram_arb #(.ACC_CYC(2), .HOST_MAX_WAIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .host_req(host_req), .host_we(host_we), .host_be(host_be), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  sram_arb #(.ACC_CYC(2), .HOST_MAX_WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req0), .vid_addr(vid_addr0), .vid_ack(vid_ack0), .vid_data(vid_data0),
    .host_req(host_req0), .host_we(host_we0), .host_be(host_be0), .host_addr(host_addr0),
    .host_wdata(host_wdata0), .host_ack(host_ack0), .host_rdata(host_rdata0),
    .sram_dq(sram_dq0), .sram_addr(sram_addr0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0),
    .sram_we_n(we_n0), .sram_ub_n(ub_n0), .sram_lb_n(lb_n0)
  );

  // A floating bus reads back as all ones.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (sram_dq[i]);
  end

  logic [15:0] mem [0:262143];
  assign sram_dq  = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  assign sram_dq0 = (!ce_n0 && !oe_n0 && we_n0) ? (sram_addr0[15:0] ^ 16'h5555) : 16'hzzzz;

  initial begin : sram_model
    mem[18'h00000] = 16'h1111;
    mem[18'h00001] = 16'h2222;
    mem[18'h00002] = 16'h3333;
    mem[18'h00003] = 16'h4444;
    mem[18'h00010] = 16'h0F0F;
    mem[18'h00020] = 16'hC0DE;
    mem[18'h00123] = 16'hBEEF;
    mem[18'h3FFFF] = 16'h1234;
    forever begin
      @(posedge we_n);
      if (!ce_n) begin
        if (!lb_n) mem[sram_addr][7:0]  = sram_dq[7:0];
        if (!ub_n) mem[sram_addr][15:8] = sram_dq[15:8];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_ce_n"}, ce_n, 1);
    chk({tag, "_oe_n"}, oe_n, 1);
    chk({tag, "_we_n"}, we_n, 1);
    chk({tag, "_ub_n"}, ub_n, 1);
    chk({tag, "_lb_n"}, lb_n, 1);
    chk({tag, "_dq_float"}, sram_dq, 16'hFFFF);
  endtask

  initial begin
    int  vpre, vpost, both, nack, cyc, last_t;
    bit  seen;

    // Reset values
    repeat (2) tick();
    chk_idle_pins("rst");
    chk("rst_addr", sram_addr, 0);
    chk("rst_vid_ack", vid_ack, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_host_rdata", host_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Single video read
    vid_addr = 18'h00123; vid_req = 1'b1;
    tick();
    chk("vrd_acc0_ce_n", ce_n, 0);
    chk("vrd_acc0_oe_n", oe_n, 0);
    chk("vrd_acc0_we_n", we_n, 1);
    chk("vrd_acc0_addr", sram_addr, 18'h00123);
    chk("vrd_acc0_ack", vid_ack, 0);
    tick();
    chk("vrd_acc1_oe_n", oe_n, 0);
    chk("vrd_acc1_ack", vid_ack, 0);
    tick();
    chk("vrd_ack", vid_ack, 1);
    chk("vrd_data", vid_data, 16'hBEEF);
    chk("vrd_done_ce_n", ce_n, 1);
    chk("vrd_no_host_ack", host_ack, 0);
    vid_req = 1'b0;
    tick();
    chk("vrd_ack_pulse", vid_ack, 0);
    chk("vrd_data_hold", vid_data, 16'hBEEF);

    // Host write, low byte only, top address
    host_addr = 18'h3FFFF; host_wdata = 16'hA55A; host_be = 2'b01; host_we = 1'b1; host_req = 1'b1;
    tick();
    chk("hwr_acc0_ce_n", ce_n, 0);
    chk("hwr_acc0_oe_n", oe_n, 1);
    chk("hwr_acc0_we_n", we_n, 0);
    chk("hwr_acc0_lb_n", lb_n, 0);
    chk("hwr_acc0_ub_n", ub_n, 1);
    chk("hwr_acc0_dq", sram_dq, 16'hA55A);
    chk("hwr_acc0_addr", sram_addr, 18'h3FFFF);
    tick();
    chk("hwr_acc1_we_n", we_n, 1);
    chk("hwr_acc1_ce_n", ce_n, 0);
    chk("hwr_acc1_dq", sram_dq, 16'hA55A);
    tick();
    chk("hwr_ack", host_ack, 1);
    chk("hwr_no_vid_ack", vid_ack, 0);
    chk_idle_pins("hwr_done");
    chk("hwr_mem", mem[18'h3FFFF], 16'h125A);
    host_req = 1'b0; host_we = 1'b0;
    tick();
    chk("hwr_ack_pulse", host_ack, 0);

    // Collision with guard at 4
    vid_addr = 18'h00010; vid_req = 1'b1;
    host_addr = 18'h00020; host_we = 1'b0; host_be = 2'b11; host_req = 1'b1;
    vpre = 0; vpost = 0; both = 0; seen = 1'b0;
    for (int i = 0; i < 80 && vpost == 0; i++) begin
      tick();
      if (vid_ack && host_ack) both++;
      if (vid_ack) begin
        if (seen) vpost++;
        else vpre++;
      end
      if (host_ack) begin
        seen = 1'b1;
        chk("col_host_rdata", host_rdata, 16'hC0DE);
        host_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    chk("col_vid_before_host", vpre, 4);
    chk("col_host_seen", seen, 1);
    chk("col_vid_after_host", vpost, 1);
    chk("col_both_acks", both, 0);
    chk("col_vid_data", vid_data, 16'h0F0F);
    tick();

    // Guard disabled: host starves until video stops
    vid_addr0 = 18'h00100; vid_req0 = 1'b1;
    host_addr0 = 18'h000AA; host_we0 = 1'b0; host_req0 = 1'b1;
    nack = 0; seen = 1'b0;
    for (int i = 0; i < 500 && nack < 100; i++) begin
      tick();
      if (host_ack0) seen = 1'b1;
      if (vid_ack0) nack++;
    end
    vid_req0 = 1'b0;
    chk("ng_vid_acks", nack, 100);
    chk("ng_host_starved", seen, 0);
    chk("ng_vid_data", vid_data0, 16'h5455);
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick();
      if (host_ack0) cyc = i;
    end
    host_req0 = 1'b0;
    chk("ng_host_latency", cyc, 4);
    chk("ng_host_rdata", host_rdata0, 16'h55FF);
    tick();

    // Reset in the first cycle of a write
    host_addr = 18'h00005; host_wdata = 16'h7777; host_be = 2'b11; host_we = 1'b1; host_req = 1'b1;
    tick();
    chk("rw_acc0_we_n", we_n, 0);
    rst_n = 1'b0; host_req = 1'b0; host_we = 1'b0;
    #1;
    chk_idle_pins("rw_async");
    tick();
    tick();
    rst_n = 1'b1;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (host_ack || vid_ack) nack++;
    end
    chk("rw_no_ack", nack, 0);
    host_addr = 18'h00006; host_wdata = 16'h1357; host_be = 2'b11; host_we = 1'b1; host_req = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick();
      if (host_ack) cyc = i;
    end
    host_req = 1'b0; host_we = 1'b0;
    chk("rw_next_latency", cyc, 3);
    chk("rw_next_mem", mem[18'h00006], 16'h1357);
    tick();

    // Back-to-back video reads with a new address in each ack cycle
    vid_addr = 18'h00000; vid_req = 1'b1;
    nack = 0; last_t = 0;
    for (int i = 1; i <= 40 && nack < 4; i++) begin
      tick();
      if (vid_ack) begin
        chk("b2b_data", vid_data, 32'h1111 * (nack + 1));
        if (nack > 0) chk("b2b_spacing", i - last_t, 4);
        last_t = i;
        nack++;
        if (nack < 4) vid_addr = 18'(nack);
        else vid_req = 1'b0;
      end
    end
    chk("b2b_count", nack, 4);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
